seq_divider: RTL and testbench

//  Iterative restoring divider. One shared subtractor is reused for WIDTH cycles, one quotient bit per cycle.

---
 rtl/div_pkg.sv | 23 ++
 rtl/sub.sv | 16 +
 rtl/seq_divider.sv | 146 ++++++++++++++
 tb/tb_seq_divider.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding
// and a constant-width helper for the iteration counter.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    CALC = S_CALC,
    DONE = S_DONE
  } state_e;

  function automatic int clog2(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << n) < v) n++;
    return n;
  endfunction

endpackage

// File: rtl/sub.sv
// Plain subtractor: diff = a - b; cout is the carry-out of a + ~b + 1,
// so cout = 1 means no borrow (a >= b).
module sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             cout
);

  assign {cout, diff} = {1'b0, a}
                      + {1'b0, ~b}
                      + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH);

  state_e           state;
  state_e           state_nxt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] d_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   t;
  logic             cout;
  logic             no_borrow;
  logic             accept;
  logic             last;
  logic             zero_div;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  sub #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a   ({r_r, q_r[WIDTH-1]}),
    .b   ({1'b0, d_r}),
    .diff(t),
    .cout(cout)
  );

  // t[WIDTH] is always 0 when cout is set, since R < D
  assign no_borrow = cout & ~t[WIDTH];
  assign r_nxt = no_borrow ? t[WIDTH-1:0]
                           : {r_r[WIDTH-2:0], q_r[WIDTH-1]};
  assign q_nxt = {q_r[WIDTH-2:0], no_borrow};
  assign last = (cnt == '0);
  assign zero_div = (divisor == '0);

`ifdef SEQ_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic q_neg;
  logic r_neg;

  assign a_mag = dividend[WIDTH-1] ? ~dividend + ONE : dividend;
  assign b_mag = divisor[WIDTH-1] ? ~divisor + ONE : divisor;
  assign q_fix = q_neg ? ~q_nxt + ONE : q_nxt;
  assign r_fix = r_neg ? ~r_nxt + ONE : r_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg <= dividend[WIDTH-1];
    end
  end
`else
  assign a_mag = dividend;
  assign b_mag = divisor;
  assign q_fix = q_nxt;
  assign r_fix = r_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        accept = start;
        if (start) state_nxt = zero_div ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        accept    = start;
        state_nxt = IDLE;
        if (start) state_nxt = zero_div ? DONE : CALC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r         <= '0;
      r_r         <= '0;
      d_r         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero_div;
      if (zero_div) begin
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        q_r <= a_mag;
        r_r <= '0;
        d_r <= b_mag;
        cnt <= CW'(WIDTH - 1);
      end
    end else if (state == CALC) begin
      q_r <= q_nxt;
      r_r <= r_nxt;
      cnt <= cnt - CW'(1);
      // results land with the move to DONE, sign already fixed
      if (last) begin
        quotient  <= q_fix;
        remainder <= r_fix;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued at
// start and compared when done pulses.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input string tag);
    exp_t e;
    e.tag = tag;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.dbz = 1'b0;
      e.lat = W + 1;
`ifdef SEQ_DIV_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        e.q = a;
        e.r = '0;
      end else begin
        e.q = $signed(a) / $signed(b);
        e.r = $signed(a) % $signed(b);
      end
`else
      e.q = a / b;
      e.r = a % b;
`endif
    end
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input string tag);
    sb.push_back(model(a, b, tag));
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // waits for done; lat is in edges counted from the start edge
  task automatic wait_done(output int lat, output int gaps);
    lat  = -1;
    gaps = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k + 1;
        break;
      end
      if (!busy) gaps++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    idle(2);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done got %b want 0", done);
    end
    n_cmp++;
    if (quotient !== '0 || remainder !== '0) begin
      n_err++;
      $display("FAIL reset_result got %h r %h want 0 r 0",
               quotient, remainder);
    end
    n_cmp++;
    if (div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dbz got %b want 0", div_by_zero);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic;
    exp_t e;
    int lat, gaps;
    issue(32'd100, 32'd7, "t1_100_7");
    wait_done(lat, gaps);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d", e.tag, lat, e.lat);
    end
    n_cmp++;
    if (gaps !== 0) begin
      n_err++;
      $display("FAIL %s busy_gaps got %0d want 0", e.tag, gaps);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_err++;
      $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
               e.tag, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    idle(1);
    n_cmp++;
    if (done !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
      n_err++;
      $display("FAIL t1_hold got done %b %h r %h want done 0 %h r %h",
               done, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_patterns;
    logic [W-1:0] a[6];
    logic [W-1:0] b[6];
    exp_t e;
    int lat, gaps;
    a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;
    a[1] = 32'd5;         b[1] = 32'd9;
    for (int i = 2; i < 6; i++) begin
      a[i] = $urandom;
      b[i] = ($urandom >> $urandom_range(0, 28)) | 32'd1;
    end
    for (int i = 0; i < 6; i++) begin
      issue(a[i], b[i], $sformatf("t2_pat%0d", i));
      wait_done(lat, gaps);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL %s latency got %0d want %0d", e.tag, lat, e.lat);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_err++;
        $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
                 e.tag, quotient, remainder, div_by_zero,
                 e.q, e.r, e.dbz);
      end
      idle(1);
    end
  endtask

  task automatic test_div_zero;
    exp_t e;
    int lat, gaps;
    issue(32'd5, 32'd0, "t3_5_0");
    wait_done(lat, gaps);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d", e.tag, lat, e.lat);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_err++;
      $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
               e.tag, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    idle(1);
    issue(32'd6, 32'd3, "t3_6_3");
    wait_done(lat, gaps);
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_err++;
      $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
               e.tag, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    idle(1);
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int lat, gaps, pulses;
    issue(32'd100, 32'd7, "t4_ignore");
    idle(9);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(lat, gaps);
    e = sb.pop_front();
    n_cmp++;
    if (lat + 10 !== e.lat) begin
      n_err++;
      $display("FAIL %s latency got %0d want %0d",
               e.tag, lat + 10, e.lat);
    end
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_err++;
      $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
               e.tag, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL t4_extra_done got %0d want 0", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a[4];
    logic [W-1:0] b[4];
    exp_t e;
    int lat, gaps;
    a[0] = 32'd20;         b[0] = 32'd6;
    a[1] = 32'd7;          b[1] = 32'd0;
    a[2] = 32'd1000;       b[2] = 32'd10;
    a[3] = 32'hDEAD_BEEF;  b[3] = 32'h1234;
    for (int i = 0; i < 4; i++) begin
      issue(a[i], b[i], $sformatf("t4_b2b%0d", i));
      wait_done(lat, gaps);
      e = sb.pop_front();
      n_cmp++;
      if (lat !== e.lat) begin
        n_err++;
        $display("FAIL %s latency got %0d want %0d", e.tag, lat, e.lat);
      end
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
        n_err++;
        $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
                 e.tag, quotient, remainder, div_by_zero,
                 e.q, e.r, e.dbz);
      end
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int lat, gaps, pulses;
    issue(32'd100, 32'd7, "t5_aborted");
    idle(14);
    rst = 1'b1;
    idle(1);
    n_cmp++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_err++;
      $display("FAIL t5_rst_flags got %b%b%b want 000",
               busy, done, div_by_zero);
    end
    n_cmp++;
    if (quotient !== '0 || remainder !== '0) begin
      n_err++;
      $display("FAIL t5_rst_result got %h r %h want 0 r 0",
               quotient, remainder);
    end
    rst = 1'b0;
    sb.delete();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      idle(1);
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL t5_stray_done got %0d want 0", pulses);
    end
    issue(32'd20, 32'd6, "t5_20_6");
    wait_done(lat, gaps);
    e = sb.pop_front();
    n_cmp++;
    if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.dbz}) begin
      n_err++;
      $display("FAIL %s result got %h r %h z %b want %h r %h z %b",
               e.tag, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    idle(1);
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed;
    logic [W-1:0] a[3];
    logic [W-1:0] b[3];
    logic [W-1:0] wq[3];
    logic [W-1:0] wr[3];
    exp_t e;
    int lat, gaps;
    a[0] = -32'sd7;      b[0] = 32'd2;
    wq[0] = -32'sd3;     wr[0] = -32'sd1;
    a[1] = 32'd7;        b[1] = -32'sd2;
    wq[1] = -32'sd3;     wr[1] = 32'd1;
    a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF;
    wq[2] = 32'h8000_0000; wr[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      issue(a[i], b[i], $sformatf("t6_signed%0d", i));
      wait_done(lat, gaps);
      e = sb.pop_front();
      n_cmp++;
      if ({quotient, remainder, div_by_zero} !== {wq[i], wr[i], 1'b0}
          || e.q !== wq[i] || e.r !== wr[i]) begin
        n_err++;
        $display("FAIL %s result got %h r %h z %b want %h r %h z 0",
                 e.tag, quotient, remainder, div_by_zero, wq[i], wr[i]);
      end
      idle(1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
